// File: rtl/estacionamiento_pkg.sv
// Shared definitions for the parking-lot entry/exit FSM and the
// occupancy counter that consumes its pulses.
package estacionamiento_pkg;

    typedef enum logic [1:0] {
        S_VACIO   = 2'd0,
        S_PARCIAL = 2'd1,
        S_LLENO   = 2'd2
    } estado_t;

    // 2-bit sensor codes {barrier A, barrier B} seen by the entry/exit FSM
    localparam logic [1:0] SENSOR_NINGUNO = 2'b00;
    localparam logic [1:0] SENSOR_A       = 2'b10;
    localparam logic [1:0] SENSOR_B       = 2'b01;
    localparam logic [1:0] SENSOR_AMBOS   = 2'b11;

endpackage

// File: rtl/contador_ocupacion_if.sv
// Event inputs and occupancy outputs of the parking occupancy counter.
interface contador_ocupacion_if #(
    parameter int ANCHO = 7
);
    logic             entrada;
    logic             salida;
    logic             clr_error;
    logic [ANCHO-1:0] ocupados;
    logic [ANCHO-1:0] libres;
    logic [3:0]       bcd_dec;
    logic [3:0]       bcd_uni;
    logic             vacio;
    logic             lleno;
    logic             error;

    modport master (
        output entrada, salida, clr_error,
        input  ocupados, libres, bcd_dec, bcd_uni,
        input  vacio, lleno, error
    );

    modport slave (
        input  entrada, salida, clr_error,
        output ocupados, libres, bcd_dec, bcd_uni,
        output vacio, lleno, error
    );
endinterface

// File: rtl/bcd_digito.sv
// One registered up/down BCD digit; carry/borrow feed the next digit
// in the same cycle the digit wraps.
module bcd_digito (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digito,
    output logic       carry,
    output logic       borrow
);
    logic [3:0] digito_q;
    logic [3:0] digito_d;

    always_comb begin
        digito_d = digito_q;
        if (inc) begin
            digito_d = (digito_q == 4'd9) ? 4'd0 : digito_q + 4'd1;
        end else if (dec) begin
            digito_d = (digito_q == 4'd0) ? 4'd9 : digito_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digito_q <= 4'd0;
        end else begin
            digito_q <= digito_d;
        end
    end

    assign carry  = inc && (digito_q == 4'd9);
    assign borrow = dec && !inc && (digito_q == 4'd0);
    assign digito = digito_q;
endmodule

// File: rtl/contador_ocupacion.sv
// Parking occupancy counter: FSM, binary count/free registers, sticky
// error flag and a two-digit BCD mirror of the count.
module contador_ocupacion
    import estacionamiento_pkg::*;
#(
    parameter int CAPACIDAD = 20,
    parameter int ANCHO     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    contador_ocupacion_if.slave  bus
);
    localparam logic [ANCHO-1:0] UNO = ANCHO'(1);
    localparam logic [ANCHO-1:0] CAP = ANCHO'(CAPACIDAD);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] ocupados_q;
    logic [ANCHO-1:0] libres_q;
    logic             vacio_q;
    logic             lleno_q;
    logic             error_q;

    logic solo_ent, solo_sal;
    logic inc_ev, dec_ev, err_ev;

    // simultaneous entrada/salida cancel out in every state
    assign solo_ent = bus.entrada && !bus.salida;
    assign solo_sal = bus.salida && !bus.entrada;
    assign inc_ev   = solo_ent && (estado_q != S_LLENO);
    assign dec_ev   = solo_sal && (estado_q != S_VACIO);
    assign err_ev   = (solo_ent && (estado_q == S_LLENO))
                   || (solo_sal && (estado_q == S_VACIO));

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            S_VACIO: begin
                if (inc_ev) begin
                    estado_d = (CAPACIDAD == 1) ? S_LLENO : S_PARCIAL;
                end
            end
            S_PARCIAL: begin
                if (inc_ev && (ocupados_q + UNO == CAP)) begin
                    estado_d = S_LLENO;
                end else if (dec_ev && (ocupados_q == UNO)) begin
                    estado_d = S_VACIO;
                end
            end
            S_LLENO: begin
                if (dec_ev) begin
                    estado_d = (CAPACIDAD == 1) ? S_VACIO : S_PARCIAL;
                end
            end
            default: estado_d = S_VACIO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= S_VACIO;
            ocupados_q <= '0;
            libres_q   <= CAP;
            vacio_q    <= 1'b1;
            lleno_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            vacio_q  <= (estado_d == S_VACIO);
            lleno_q  <= (estado_d == S_LLENO);
            if (inc_ev) begin
                ocupados_q <= ocupados_q + UNO;
                libres_q   <= libres_q - UNO;
            end else if (dec_ev) begin
                ocupados_q <= ocupados_q - UNO;
                libres_q   <= libres_q + UNO;
            end
            // a new illegal event wins over a same-cycle clear
            error_q <= (error_q && !bus.clr_error) || err_ev;
        end
    end

    logic carry_uni, borrow_uni;
    logic unused_carry_dec, unused_borrow_dec;

    bcd_digito u_uni (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc_ev),
        .dec    (dec_ev),
        .digito (bus.bcd_uni),
        .carry  (carry_uni),
        .borrow (borrow_uni)
    );

    bcd_digito u_dec (
        .clk    (clk),
        .rst    (rst),
        .inc    (carry_uni),
        .dec    (borrow_uni),
        .digito (bus.bcd_dec),
        .carry  (unused_carry_dec),
        .borrow (unused_borrow_dec)
    );

    assign bus.ocupados = ocupados_q;
    assign bus.libres   = libres_q;
    assign bus.vacio    = vacio_q;
    assign bus.lleno    = lleno_q;
    assign bus.error    = error_q;
endmodule
